delay_steer_ctrl: RTL and testbench

//   Steering controller for the per-microphone delay_line bank in the beamformer.
//   On a steer request it fetches one tap-delay per channel from an external

---
 rtl/delay_steer_ctrl.sv | 124 ++++++++++++
 tb/tb_delay_steer_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_steer_ctrl.sv
// Steering controller: fetches one tap delay per channel from the angle/channel
// table into shadow registers, then commits all channels together on a PCM strobe.
module delay_steer_ctrl #(
    parameter int NUM_CH    = 8,
    parameter int CH_W      = 3,
    parameter int DELAY_W   = 4,
    parameter int MAX_DELAY = 16,
    parameter int ANGLE_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_valid,
    input  logic                        steer_valid,
    input  logic [ANGLE_W-1:0]          steer_angle,
    output logic                        steer_ready,
    output logic                        tbl_rd_en,
    output logic [ANGLE_W+CH_W-1:0]     tbl_addr,
    input  logic [DELAY_W:0]            tbl_data,
    output logic [NUM_CH*DELAY_W-1:0]   delays_out,
    output logic                        delays_update,
    output logic [ANGLE_W-1:0]          cur_angle,
    output logic                        clamp_err,
    input  logic                        clamp_clr
);

    localparam int TW = DELAY_W + 1;
    localparam logic [DELAY_W:0] MAX_TAP = TW'(MAX_DELAY - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ARM} state_t;

    state_t                          state_q, state_d;
    logic [CH_W-1:0]                 ch_q, ch_d;
    logic [ANGLE_W-1:0]              ang_q, ang_d;
    logic                            cap_vld_q;
    logic [CH_W-1:0]                 cap_ch_q;
    logic [NUM_CH-1:0][DELAY_W-1:0]  shadow_q;
    logic [NUM_CH*DELAY_W-1:0]       delays_q;
    logic [ANGLE_W-1:0]              cur_q;
    logic                            upd_q;
    logic                            clamp_q;
    logic                            commit;
    logic                            over;
    logic [DELAY_W-1:0]              cap_val;

    assign over    = tbl_data > MAX_TAP;
    assign cap_val = over ? MAX_TAP[DELAY_W-1:0] : tbl_data[DELAY_W-1:0];

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        ang_d       = ang_q;
        steer_ready = 1'b0;
        tbl_rd_en   = 1'b0;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                steer_ready = !rst;
                if (steer_valid) begin
                    ang_d   = steer_angle;
                    ch_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                tbl_rd_en = 1'b1;
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    ch_d    = '0;
                    state_d = DRAIN;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            DRAIN: state_d = ARM;
            ARM: begin
                if (sample_valid) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Table data lags its read by one cycle; the pipelined channel tag steers it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            ang_q     <= '0;
            cap_vld_q <= 1'b0;
            cap_ch_q  <= '0;
            shadow_q  <= '0;
            delays_q  <= '0;
            cur_q     <= '0;
            upd_q     <= 1'b0;
            clamp_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            ang_q     <= ang_d;
            cap_vld_q <= tbl_rd_en;
            cap_ch_q  <= ch_q;
            if (cap_vld_q)
                shadow_q[cap_ch_q] <= cap_val;
            // A new clamp event takes priority over a simultaneous clear.
            if (cap_vld_q && over)
                clamp_q <= 1'b1;
            else if (clamp_clr)
                clamp_q <= 1'b0;
            if (commit) begin
                delays_q <= shadow_q;
                cur_q    <= ang_q;
            end
            upd_q <= commit;
        end
    end

    assign tbl_addr      = {ang_q, ch_q};
    assign delays_out    = delays_q;
    assign delays_update = upd_q;
    assign cur_angle     = cur_q;
    assign clamp_err     = clamp_q;

endmodule

// File: tb/tb_delay_steer_ctrl.sv
// Bench for delay_steer_ctrl: directed steps plus randomized steers against a
// table-driven model of the committed delays and commit timing.
module tb_delay_steer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic        steer_valid;
    logic [3:0]  steer_angle;
    logic        steer_ready;
    logic        tbl_rd_en;
    logic [6:0]  tbl_addr;
    logic [4:0]  tbl_data;
    logic [31:0] delays_out;
    logic        delays_update;
    logic [3:0]  cur_angle;
    logic        clamp_err;
    logic        clamp_clr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int upd_cnt = 0;

    logic [4:0] tbl [16][8];

    delay_steer_ctrl dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .steer_valid(steer_valid), .steer_angle(steer_angle), .steer_ready(steer_ready),
        .tbl_rd_en(tbl_rd_en), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .delays_out(delays_out), .delays_update(delays_update), .cur_angle(cur_angle),
        .clamp_err(clamp_err), .clamp_clr(clamp_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Table memory: one-cycle read latency, garbage when not reading.
    always @(posedge clk)
        tbl_data <= tbl_rd_en ? tbl[tbl_addr[6:3]][tbl_addr[2:0]] : 5'($urandom);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Any change of delays_out outside reset must coincide with an update pulse.
    logic [31:0] prev_d = '0;
    logic        prev_rst = 1'b1;
    always @(negedge clk) begin
        if (delays_update === 1'b1) upd_cnt++;
        if (!prev_rst && !rst && delays_out !== prev_d)
            chk("change_has_pulse", delays_update, 1);
        prev_d   = delays_out;
        prev_rst = rst;
    end

    function automatic logic [31:0] model(input int a);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++)
            r[k*4 +: 4] = (tbl[a][k] > 15) ? 4'd15 : tbl[a][k][3:0];
        return r;
    endfunction

    task automatic accept(input int a, input bit hold, output int n);
        steer_valid = 1'b1;
        steer_angle = 4'(a);
        for (int i = 0; i < 100 && !steer_ready; i++) @(negedge clk);
        if (!steer_ready) chk("ready_timeout", steer_ready, 1);
        @(posedge clk); #1;
        n = cyc;
        if (!hold) steer_valid = 1'b0;
        steer_angle = 4'($urandom);
    endtask

    task automatic run_steer(input int a, input bit strobe_during, input bit clr_during,
                             input bit hold, input int arm_wait, output int n, output int u);
        logic [31:0] expd;
        int w;
        expd = model(a);
        w = strobe_during ? 0 : arm_wait;
        accept(a, hold, n);
        sample_valid = strobe_during;
        clamp_clr    = clr_during;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("fetch_rd_en", tbl_rd_en, 1);
            chk("fetch_addr", tbl_addr, 64'((a << 3) | k));
            chk("busy_ready", steer_ready, 0);
            chk("no_early_update", delays_update, 0);
            @(posedge clk); #1;
            if (hold) steer_angle = 4'($urandom);
        end
        @(negedge clk);
        chk("drain_rd_en", tbl_rd_en, 0);
        chk("drain_ready", steer_ready, 0);
        @(posedge clk); #1;
        clamp_clr = 1'b0;
        if (!strobe_during) begin
            sample_valid = 1'b0;
            repeat (arm_wait) begin
                @(negedge clk);
                chk("arm_ready", steer_ready, 0);
                @(posedge clk); #1;
            end
            sample_valid = 1'b1;
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
        u = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (delays_update === 1'b1) begin
                u = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (u < 0) chk("upd_timeout", delays_update, 1);
        chk("commit_cycle", u, n + 10 + w);
        chk("delays_out", delays_out, expd);
        chk("cur_angle", cur_angle, a);
        chk("ready_after", steer_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, u, n2, u2, c0, a;
        bit clamp_exp;
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 8; k++) tbl[i][k] = 5'($urandom_range(0, 15));

        // Reset: outputs quiet, not ready even with a request present.
        rst = 1'b1; sample_valid = 1'b0; steer_valid = 1'b1; steer_angle = 4'd9; clamp_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", steer_ready, 0);
        chk("rst_delays", delays_out, 0);
        chk("rst_update", delays_update, 0);
        chk("rst_rd_en", tbl_rd_en, 0);
        chk("rst_addr", tbl_addr, 0);
        chk("rst_clamp", clamp_err, 0);
        chk("rst_angle", cur_angle, 0);
        @(posedge clk); #1;
        rst = 1'b0; steer_valid = 1'b0;

        // 1: angle 3 with table[3][k]=k.
        for (int k = 0; k < 8; k++) tbl[3][k] = 5'(k);
        run_steer(3, 0, 0, 0, 2, n, u);
        chk("t1_delays", delays_out, 32'h7654_3210);
        chk("t1_clamp", clamp_err, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_pulse_end", delays_update, 0);

        // 2: strobe every cycle through fetch; commits on first ARM cycle.
        run_steer(7, 1, 0, 0, 0, n, u);

        // 3: clamp on ch5, sticky, clear, then set-wins-over-clear.
        for (int k = 0; k < 8; k++) tbl[5][k] = 5'($urandom_range(0, 15));
        tbl[5][5] = 5'd20;
        run_steer(5, 0, 0, 0, 1, n, u);
        chk("t3_ch5", delays_out[23:20], 15);
        chk("t3_clamp", clamp_err, 1);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t3_sticky", clamp_err, 1);
        @(posedge clk); #1; clamp_clr = 1'b1;
        @(posedge clk); #1; clamp_clr = 1'b0;
        @(negedge clk);
        chk("t3_cleared", clamp_err, 0);
        for (int k = 0; k < 8; k++) tbl[6][k] = 5'($urandom_range(0, 15));
        tbl[6][7] = 5'd31;
        run_steer(6, 0, 1, 0, 0, n, u);
        chk("t3_set_wins", clamp_err, 1);
        chk("t3_ch7", delays_out[31:28], 15);

        // 4: request held with changing angles; back-to-back accept after commit.
        run_steer(8, 0, 0, 1, 3, n, u);
        run_steer(9, 0, 0, 1, 0, n2, u2);
        steer_valid = 1'b0;
        chk("t4_b2b_accept", n2, u + 1);

        // 5: reset during fetch of channel 4 aborts everything.
        accept(10, 0, n);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        chk("t5_addr_ch4", tbl_addr, 64'((10 << 3) | 4));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ready", steer_ready, 1);
        chk("t5_delays", delays_out, 0);
        chk("t5_update", delays_update, 0);
        chk("t5_rd_en", tbl_rd_en, 0);
        chk("t5_addr", tbl_addr, 0);
        chk("t5_clamp", clamp_err, 0);
        c0 = upd_cnt;
        @(posedge clk); #1;
        sample_valid = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("t5_no_commit", delays_out, 0);
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        chk("t5_no_pulse", upd_cnt, c0);

        // 6: two steers 50 cycles apart -> exactly two pulses.
        c0 = upd_cnt;
        run_steer(1, 0, 0, 0, 0, n, u);
        repeat (50) begin @(posedge clk); #1; end
        run_steer(2, 0, 0, 0, 4, n, u);
        @(posedge clk); #1;
        chk("t6_pulses", upd_cnt - c0, 2);

        // Randomized steers, entries may exceed the deepest tap.
        clamp_exp = 1'b0;
        repeat (6) begin
            a = $urandom_range(11, 15);
            for (int k = 0; k < 8; k++) begin
                tbl[a][k] = 5'($urandom_range(0, 19));
                if (tbl[a][k] > 15) clamp_exp = 1'b1;
            end
            run_steer(a, 1'($urandom_range(0, 1)), 0, 0, $urandom_range(0, 5), n, u);
            chk("rnd_clamp", clamp_err, clamp_exp);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
